// File: rtl/demux_pkg.sv
// Shared types and sizing for the 1:4 stream demultiplexer.
package demux_pkg;

    localparam int N_CH          = 4;
    localparam int CNT_W_DEFAULT = 8;

    typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/demux_slot.sv
// One output channel: a one-entry holding register with valid/ready handshake
// and a wrapping count of words loaded into it.
module demux_slot #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             ready,
    output logic [W-1:0]     data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt,
    output logic             can_load
);

    // Slot is free, or its word leaves on this edge so a new one can replace it.
    assign can_load = ~valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
            cnt   <= cnt + 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1_4_stream.sv
// Registered 1:4 stream demultiplexer: each accepted word is steered by in_sel
// into one of four independent holding slots.
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [W-1:0]          in_data,
    input  ch_sel_t               in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [W-1:0]          out0_data,
    output logic [W-1:0]          out1_data,
    output logic [W-1:0]          out2_data,
    output logic [W-1:0]          out3_data,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic [N_CH*CNT_W-1:0] cnt
);

    logic [N_CH-1:0] load;
    logic [N_CH-1:0] can_load;
    logic [W-1:0]    slot_data [N_CH];

    // Only the targeted slot can stall the input; the others never see a load.
    assign in_ready = can_load[in_sel];

    always_comb begin
        load = '0;
        for (int k = 0; k < N_CH; k++) begin
            load[k] = in_valid & in_ready & (in_sel == ch_sel_t'(k));
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        demux_slot #(
            .W     (W),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .data      (slot_data[k]),
            .valid     (out_valid[k]),
            .cnt       (cnt[k*CNT_W +: CNT_W]),
            .can_load  (can_load[k])
        );
    end

    assign out0_data = slot_data[0];
    assign out1_data = slot_data[1];
    assign out2_data = slot_data[2];
    assign out3_data = slot_data[3];

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed scoreboard bench for demux_1_4_stream: per-channel queues of expected
// words, filled on accept and drained when the consumer takes a word.
module tb_demux_1_4_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out0_data, out1_data, out2_data, out3_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] cnt;

    logic [3:0]  od [4];
    assign od[0] = out0_data;
    assign od[1] = out1_data;
    assign od[2] = out2_data;
    assign od[3] = out3_data;

    always #5 clk = ~clk;

    demux_1_4_stream #(.W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt       (cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] q [4][$];
    logic [3:0] mvalid;
    logic [7:0] mcnt [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", {28'd0, out_valid}, {28'd0, mvalid});
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cnt%0d", k), {24'd0, cnt[k*8 +: 8]}, {24'd0, mcnt[k]});
            if (mvalid[k] && q[k].size() > 0)
                chk($sformatf("hold_data%0d", k), {28'd0, od[k]}, {28'd0, q[k][0]});
        end
    endtask

    task automatic model_clear();
        mvalid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            mcnt[k] = 8'd0;
            q[k].delete();
        end
    endtask

    // Drive one cycle of stimulus, score it, advance the model and the DUT one edge.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
        logic       er;
        logic [3:0] w;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        er = ~mvalid[s] | r[s];
        chk($sformatf("in_ready_sel%0d", s), {31'd0, in_ready}, {31'd0, er});
        for (int k = 0; k < 4; k++) begin
            if (mvalid[k] && r[k]) begin
                chk($sformatf("sb_depth%0d", k), q[k].size(), 1);
                if (q[k].size() > 0) begin
                    w = q[k].pop_front();
                    chk($sformatf("drain%0d", k), {28'd0, od[k]}, {28'd0, w});
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (v && er && s == 2'(k)) begin
                q[k].push_back(d);
                mvalid[k] = 1'b1;
                mcnt[k]++;
            end else if (mvalid[k] && r[k]) begin
                mvalid[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, {28'd0, out_valid}, 32'd0);
        chk({tag, "_cnt"}, cnt, 32'd0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_data%0d", tag, k), {28'd0, od[k]}, 32'd0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("%s_in_ready_sel%0d", tag, s), {31'd0, in_ready}, 32'd1);
        end
    endtask

    // Asynchronous reset taken away from the clock edge, released on a falling edge.
    task automatic do_reset(input string tag);
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_reset_values(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 4'h0;
        out_ready = 4'b0000;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-stream with channels 0 and 2 holding words
        cycle(1'b1, 2'd0, 4'h1, 4'b0000);
        cycle(1'b1, 2'd2, 4'h2, 4'b0000);
        chk("pre_reset_valid", {28'd0, out_valid}, 32'h5);
        do_reset("midrst");

        // Routing a,b,c,d to channels 0..3 with all consumers stalled
        cycle(1'b1, 2'd0, 4'hA, 4'b0000);
        cycle(1'b1, 2'd1, 4'hB, 4'b0000);
        cycle(1'b1, 2'd2, 4'hC, 4'b0000);
        cycle(1'b1, 2'd3, 4'hD, 4'b0000);
        chk("route_valid", {28'd0, out_valid}, 32'hF);
        chk("route_cnt", cnt, 32'h01010101);
        chk("route_d0", {28'd0, out0_data}, 32'hA);
        chk("route_d3", {28'd0, out3_data}, 32'hD);
        for (int s = 0; s < 4; s++)
            cycle(1'b0, 2'(s), 4'h0, 4'b0000);

        // Backpressure isolation: channel 0 stalled, the others drain
        cycle(1'b1, 2'd0, 4'h7, 4'b1110);
        chk("bp_hold0", {28'd0, out0_data}, 32'hA);
        cycle(1'b1, 2'd2, 4'h3, 4'b1110);
        chk("bp_accept2", {28'd0, out2_data}, 32'h3);
        chk("bp_hold0_again", {28'd0, out0_data}, 32'hA);

        // Streaming eight words to channel 1
        do_reset("rst2");
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 2'd1, 4'(i), 4'b0010);
        cycle(1'b0, 2'd1, 4'h0, 4'b0010);
        chk("stream_cnt1", {24'd0, cnt[15:8]}, 32'd8);
        chk("stream_sb_empty", q[1].size(), 0);

        // Counter wrap on channel 3
        for (int i = 0; i < 256; i++)
            cycle(1'b1, 2'd3, 4'(i), 4'b1000);
        cycle(1'b0, 2'd3, 4'h0, 4'b1000);
        chk("wrap_cnt3", {24'd0, cnt[31:24]}, 32'd0);
        chk("wrap_cnt1", {24'd0, cnt[15:8]}, 32'd8);

        // Simultaneous drain and load on channel 2
        cycle(1'b1, 2'd2, 4'h5, 4'b0000);
        chk("dl_pre", {28'd0, out2_data}, 32'h5);
        cycle(1'b1, 2'd2, 4'h9, 4'b0100);
        chk("dl_data", {28'd0, out2_data}, 32'h9);
        chk("dl_valid2", {31'd0, out_valid[2]}, 32'd1);
        cycle(1'b0, 2'd2, 4'h0, 4'b0100);

        // Unknown select while idle must not disturb state
        cycle(1'b1, 2'd0, 4'hE, 4'b0000);
        in_valid = 1'b0;
        in_sel   = 2'bxx;
        @(posedge clk);
        #1;
        check_state();
        chk("x_sel_hold0", {28'd0, out0_data}, 32'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
